if_id_queue: RTL and testbench

- IF/ID boundary block, directly downstream of the fetch stage.
- Captures each fetched {pc, instruction} pair into a small skid queue and presents it to decode with a valid/ready handshake.
- Drives the fetch stage's pc_en so that fetch stalls only when the queue is full. This keeps the decode-ready path out of the PC enable path.
- Discards wrong-path instructions on a jump/branch redirect and injects NOP bubbles whenever decode has nothing valid.

---
 rtl/if_id_queue_pkg.sv | 24 ++
 rtl/if_id_queue_if.sv | 24 ++
 rtl/if_id_queue_fifo.sv | 64 ++++++
 rtl/if_id_queue.sv | 82 ++++++++
 tb/tb_if_id_queue.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/if_id_queue_pkg.sv
// rtl/if_id_queue_pkg.sv - shared types and constants for the IF/ID queue
// Holds the bubble encoding, FSM state encoding and queue entry layout.
package if_id_queue_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    WARMUP   = 2'd0,
    RUN      = 2'd1,
    REDIRECT = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instruction;
  } if_id_entry_t;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage

// File: rtl/if_id_queue_if.sv
// rtl/if_id_queue_if.sv - fetch-side and decode-side signals of the IF/ID queue
// The queue is the slave; the surrounding pipeline (or bench) is the master.
interface if_id_queue_if;

  logic [31:0] if_pc;
  logic [31:0] if_instruction;
  logic        flush;
  logic        pc_en;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instruction;

  modport slave (
    input  if_pc, if_instruction, flush, id_ready,
    output pc_en, id_valid, id_pc, id_instruction
  );

  modport master (
    output if_pc, if_instruction, flush, id_ready,
    input  pc_en, id_valid, id_pc, id_instruction
  );

endinterface

// File: rtl/if_id_queue_fifo.sv
// rtl/if_id_queue_fifo.sv - generic DEPTH-entry synchronous FIFO with flush-clear
// Pointers wrap modulo DEPTH so non-power-of-two depths are supported.
module if_id_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush_i,
  input  logic                           wr_en_i,
  input  logic [WIDTH-1:0]               wr_data_i,
  input  logic                           rd_en_i,
  output logic [WIDTH-1:0]               rd_data_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o,
  output logic                           full_o,
  output logic                           empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             wr_ok, rd_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign wr_ok   = wr_en_i & ~full_o & ~flush_i;
  assign rd_ok   = rd_en_i & ~empty_o;
  assign count_o = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_ok) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (rd_ok) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({wr_ok, rd_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: an empty count hides stale entries.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/if_id_queue.sv
// rtl/if_id_queue.sv - IF/ID skid queue with redirect flush and NOP bubble injection
// pc_en depends only on the registered occupancy and flush, never on id_ready.
module if_id_queue #(
  parameter int          DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = if_id_queue_pkg::NOP_INSTR
) (
  input  logic                 clk,
  input  logic                 rst,
  if_id_queue_if.slave         bus,
  output logic [15:0]          dropped_cnt
);

  import if_id_queue_pkg::*;

  localparam int CW = $clog2(DEPTH + 1);

  state_e         state_q, state_d;
  logic [15:0]    dropped_q, dropped_d;
  logic [15:0]    drop_inc;
  logic [CW-1:0]  count;
  logic           full, empty;
  logic           pc_en, enq, deq;
  if_id_entry_t   wr_entry, head;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= WARMUP;
      dropped_q <= '0;
    end else begin
      state_q   <= state_d;
      dropped_q <= dropped_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_en   = 1'b0;
    unique case (state_q)
      WARMUP: state_d = RUN;
      RUN, REDIRECT: begin
        pc_en   = ~full | bus.flush;
        state_d = bus.flush ? REDIRECT : RUN;
      end
      default: state_d = WARMUP;
    endcase
  end

  assign enq = pc_en & ~bus.flush;
  assign deq = ~empty & bus.id_ready;

  // Flush drops what remains after this cycle's handshake plus the live fetch pair.
  always_comb begin
    drop_inc  = 16'(count) - 16'(deq) + 16'(state_q != WARMUP);
    dropped_d = dropped_q;
    if (bus.flush) dropped_d = sat_add16(dropped_q, drop_inc);
  end

  assign wr_entry = '{pc: bus.if_pc, instruction: bus.if_instruction};

  if_id_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(if_id_entry_t))
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst),
    .flush_i   (bus.flush),
    .wr_en_i   (enq),
    .wr_data_i (wr_entry),
    .rd_en_i   (deq),
    .rd_data_o (head),
    .count_o   (count),
    .full_o    (full),
    .empty_o   (empty)
  );

  assign bus.pc_en          = pc_en;
  assign bus.id_valid       = ~empty;
  assign bus.id_pc          = empty ? 32'h0 : head.pc;
  assign bus.id_instruction = empty ? NOP_INSTR : head.instruction;
  assign dropped_cnt        = dropped_q;

endmodule

// File: tb/tb_if_id_queue.sv
// tb/tb_if_id_queue.sv - directed self-checking bench for if_id_queue
// The bench models the fetch PC register that pc_en and flush steer.
module tb_if_id_queue;

  import if_id_queue_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] dropped_cnt;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] fetch_pc = 32'h0;
  logic [31:0] target = 32'h0;

  if_id_queue_if qif();

  if_id_queue #(.DEPTH(2), .NOP_INSTR(32'h0000_0013)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (qif),
    .dropped_cnt (dropped_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return 32'h0050_0093 ^ (pc << 20);
  endfunction

  task automatic drive_fetch();
    qif.if_pc          = fetch_pc;
    qif.if_instruction = instr_of(fetch_pc);
  endtask

  task automatic tick();
    logic en, fl;
    en = qif.pc_en;
    fl = qif.flush;
    @(posedge clk);
    #1;
    if (fl) fetch_pc = target;
    else if (en) fetch_pc = fetch_pc + 32'd4;
    drive_fetch();
  endtask

  task automatic test_reset();
    qif.flush = 1'b0; qif.id_ready = 1'b0; fetch_pc = 32'h0; drive_fetch();
    #2 rst = 1'b0;
    #1;
    checks++; if (qif.pc_en !== 1'b0) begin failures++; $display("FAIL rst_pc_en got=%b exp=0", qif.pc_en); end
    checks++; if (qif.id_valid !== 1'b0) begin failures++; $display("FAIL rst_id_valid got=%b exp=0", qif.id_valid); end
    checks++; if (qif.id_pc !== 32'h0) begin failures++; $display("FAIL rst_id_pc got=%h exp=0", qif.id_pc); end
    checks++; if (qif.id_instruction !== 32'h0000_0013) begin failures++; $display("FAIL rst_id_instr got=%h exp=00000013", qif.id_instruction); end
    checks++; if (dropped_cnt !== 16'h0) begin failures++; $display("FAIL rst_dropped got=%h exp=0", dropped_cnt); end
    @(posedge clk); #1;
    rst = 1'b1;
    checks++; if (qif.pc_en !== 1'b0) begin failures++; $display("FAIL warmup_pc_en got=%b exp=0", qif.pc_en); end
    tick();
    checks++; if (qif.pc_en !== 1'b1) begin failures++; $display("FAIL run_pc_en got=%b exp=1", qif.pc_en); end
    checks++; if (qif.id_valid !== 1'b0) begin failures++; $display("FAIL run_id_valid got=%b exp=0", qif.id_valid); end
    tick();
    checks++; if (qif.id_valid !== 1'b1) begin failures++; $display("FAIL first_valid got=%b exp=1", qif.id_valid); end
    checks++; if (qif.id_pc !== 32'h0) begin failures++; $display("FAIL first_pc got=%h exp=0", qif.id_pc); end
    checks++; if (qif.id_instruction !== 32'h0050_0093) begin failures++; $display("FAIL first_instr got=%h exp=00500093", qif.id_instruction); end
  endtask

  task automatic test_streaming();
    qif.id_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (qif.id_valid !== 1'b1) begin failures++; $display("FAIL stream_valid[%0d] got=%b exp=1", i, qif.id_valid); end
      checks++; if (qif.id_pc !== 32'(4 * i)) begin failures++; $display("FAIL stream_pc[%0d] got=%h exp=%h", i, qif.id_pc, 32'(4 * i)); end
      checks++; if (qif.pc_en !== 1'b1) begin failures++; $display("FAIL stream_pc_en[%0d] got=%b exp=1", i, qif.pc_en); end
      tick();
    end
  endtask

  task automatic test_backpressure();
    qif.id_ready = 1'b0;
    checks++; if (qif.id_pc !== 32'd16) begin failures++; $display("FAIL bp_head got=%h exp=10", qif.id_pc); end
    checks++; if (qif.pc_en !== 1'b1) begin failures++; $display("FAIL bp_pc_en0 got=%b exp=1", qif.pc_en); end
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++; if (qif.pc_en !== 1'b0) begin failures++; $display("FAIL bp_full_pc_en[%0d] got=%b exp=0", i, qif.pc_en); end
      checks++; if (qif.id_pc !== 32'd16) begin failures++; $display("FAIL bp_hold_pc[%0d] got=%h exp=10", i, qif.id_pc); end
      tick();
    end
    qif.id_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (qif.id_pc !== 32'(16 + 4 * i)) begin failures++; $display("FAIL bp_drain_pc[%0d] got=%h exp=%h", i, qif.id_pc, 32'(16 + 4 * i)); end
      tick();
    end
  endtask

  task automatic test_flush_full();
    qif.id_ready = 1'b0;
    tick();
    checks++; if (qif.pc_en !== 1'b0) begin failures++; $display("FAIL ff_full_pc_en got=%b exp=0", qif.pc_en); end
    checks++; if (qif.id_pc !== 32'd28) begin failures++; $display("FAIL ff_head got=%h exp=1c", qif.id_pc); end
    qif.flush = 1'b1; target = 32'h100;
    #1;
    checks++; if (qif.pc_en !== 1'b1) begin failures++; $display("FAIL ff_flush_pc_en got=%b exp=1", qif.pc_en); end
    tick();
    qif.flush = 1'b0;
    checks++; if (qif.id_valid !== 1'b0) begin failures++; $display("FAIL ff_valid got=%b exp=0", qif.id_valid); end
    checks++; if (qif.id_instruction !== 32'h0000_0013) begin failures++; $display("FAIL ff_nop got=%h exp=00000013", qif.id_instruction); end
    checks++; if (qif.id_pc !== 32'h0) begin failures++; $display("FAIL ff_id_pc got=%h exp=0", qif.id_pc); end
    checks++; if (dropped_cnt !== 16'd3) begin failures++; $display("FAIL ff_dropped got=%0d exp=3", dropped_cnt); end
    tick();
    checks++; if (qif.id_valid !== 1'b1) begin failures++; $display("FAIL ff_target_valid got=%b exp=1", qif.id_valid); end
    checks++; if (qif.id_pc !== 32'h100) begin failures++; $display("FAIL ff_target_pc got=%h exp=100", qif.id_pc); end
    checks++; if (qif.id_instruction !== 32'h1050_0093) begin failures++; $display("FAIL ff_target_instr got=%h exp=10500093", qif.id_instruction); end
  endtask

  task automatic test_flush_dequeue();
    qif.id_ready = 1'b1; qif.flush = 1'b1; target = 32'h200;
    #1;
    checks++; if (qif.id_valid !== 1'b1) begin failures++; $display("FAIL fd_handshake got=%b exp=1", qif.id_valid); end
    tick();
    qif.flush = 1'b0;
    checks++; if (qif.id_valid !== 1'b0) begin failures++; $display("FAIL fd_empty got=%b exp=0", qif.id_valid); end
    checks++; if (dropped_cnt !== 16'd4) begin failures++; $display("FAIL fd_dropped got=%0d exp=4", dropped_cnt); end
    tick();
    checks++; if (qif.id_pc !== 32'h200) begin failures++; $display("FAIL fd_target_pc got=%h exp=200", qif.id_pc); end
  endtask

  task automatic test_back_to_back();
    qif.id_ready = 1'b0; qif.flush = 1'b1; target = 32'h300;
    tick();
    target = 32'h400;
    checks++; if (dut.state_q !== REDIRECT) begin failures++; $display("FAIL b2b_state1 got=%0d exp=%0d", dut.state_q, REDIRECT); end
    checks++; if (dropped_cnt !== 16'd6) begin failures++; $display("FAIL b2b_dropped1 got=%0d exp=6", dropped_cnt); end
    tick();
    qif.flush = 1'b0;
    checks++; if (dut.state_q !== REDIRECT) begin failures++; $display("FAIL b2b_state2 got=%0d exp=%0d", dut.state_q, REDIRECT); end
    checks++; if (dropped_cnt !== 16'd7) begin failures++; $display("FAIL b2b_dropped2 got=%0d exp=7", dropped_cnt); end
    checks++; if (qif.id_valid !== 1'b0) begin failures++; $display("FAIL b2b_valid got=%b exp=0", qif.id_valid); end
    tick();
    checks++; if (qif.id_pc !== 32'h400) begin failures++; $display("FAIL b2b_target_pc got=%h exp=400", qif.id_pc); end
    checks++; if (dut.state_q !== RUN) begin failures++; $display("FAIL b2b_state_run got=%0d exp=%0d", dut.state_q, RUN); end
    tick();
    checks++; if (qif.pc_en !== 1'b0) begin failures++; $display("FAIL b2b_full_pc_en got=%b exp=0", qif.pc_en); end
    checks++; if (qif.id_pc !== 32'h400) begin failures++; $display("FAIL b2b_head_pc got=%h exp=400", qif.id_pc); end
  endtask

  task automatic test_reset_midstream();
    rst = 1'b0;
    #1;
    checks++; if (qif.pc_en !== 1'b0) begin failures++; $display("FAIL mrst_pc_en got=%b exp=0", qif.pc_en); end
    checks++; if (qif.id_valid !== 1'b0) begin failures++; $display("FAIL mrst_valid got=%b exp=0", qif.id_valid); end
    checks++; if (qif.id_pc !== 32'h0) begin failures++; $display("FAIL mrst_id_pc got=%h exp=0", qif.id_pc); end
    checks++; if (qif.id_instruction !== 32'h0000_0013) begin failures++; $display("FAIL mrst_instr got=%h exp=00000013", qif.id_instruction); end
    checks++; if (dropped_cnt !== 16'h0) begin failures++; $display("FAIL mrst_dropped got=%0d exp=0", dropped_cnt); end
    fetch_pc = 32'h0; drive_fetch();
    @(posedge clk); #1;
    rst = 1'b1;
    checks++; if (qif.pc_en !== 1'b0) begin failures++; $display("FAIL mrst_warmup got=%b exp=0", qif.pc_en); end
    tick();
    checks++; if (qif.pc_en !== 1'b1) begin failures++; $display("FAIL mrst_run got=%b exp=1", qif.pc_en); end
    checks++; if (qif.id_valid !== 1'b0) begin failures++; $display("FAIL mrst_stale got=%b exp=0", qif.id_valid); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush_full();
    test_flush_dequeue();
    test_back_to_back();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
